// File: rtl/modulo_controlador_transferencia_rolhas_pkg.sv
// Shared constants and state encoding for the cork transfer controller,
// also used by the display encoders and the filling/sealing MEF.
package modulo_controlador_transferencia_rolhas_pkg;

    localparam int unsigned LARGURA = 7;
    localparam int unsigned CAP_MAX = 99;
    localparam int unsigned MINIMO  = 5;
    localparam int unsigned LOTE    = 20;

    typedef enum logic [1:0] {
        EST_IDLE = 2'd0,
        EST_LOAD = 2'd1,
        EST_XFER = 2'd2
    } estado_t;

endpackage

// File: rtl/modulo_controlador_transferencia_rolhas_contador.sv
// Loadable down-counter holding the corks left in the current refill batch.
module modulo_contador_lote #(
    parameter int unsigned LARGURA = 7
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               enable,
    input  logic [LARGURA-1:0] valor,
    output logic [LARGURA-1:0] contagem,
    output logic               zero
);

    assign zero = (contagem == '0);

    // Load wins over counting; the count never wraps below zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (enable && !zero) begin
            contagem <= contagem - LARGURA'(1);
        end
    end

endmodule

// File: rtl/modulo_controlador_transferencia_rolhas.sv
// Arbitrates operator loads, secondary-to-main refills and per-bottle
// consumption over the two cork buffers.
module modulo_controlador_transferencia_rolhas #(
    parameter int unsigned LARGURA = modulo_controlador_transferencia_rolhas_pkg::LARGURA,
    parameter int unsigned CAP_MAX = modulo_controlador_transferencia_rolhas_pkg::CAP_MAX,
    parameter int unsigned MINIMO  = modulo_controlador_transferencia_rolhas_pkg::MINIMO,
    parameter int unsigned LOTE    = modulo_controlador_transferencia_rolhas_pkg::LOTE
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enable,
    input  logic               req_carga,
    input  logic [LARGURA-1:0] qtd_carga,
    input  logic               consumo,
    output logic [LARGURA-1:0] buf_principal,
    output logic [LARGURA-1:0] buf_secundario,
    output logic               ro,
    output logic               transferindo,
    output logic               erro_carga,
    output logic [1:0]         estado
);
    import modulo_controlador_transferencia_rolhas_pkg::*;

    estado_t            est, est_prox;
    logic               pendente;
    logic [LARGURA-1:0] qtd_reg;
    logic [LARGURA:0]   soma;
    logic               cabe;
    logic [LARGURA-1:0] folga;
    logic [LARGURA-1:0] lote_ini;
    logic [LARGURA-1:0] lote_cnt;
    logic               lote_zero;
    logic               carrega_lote;
    logic               passo_xfer;
    logic               passo_cons;

    assign ro     = (buf_principal == '0);
    assign estado = est;

    modulo_contador_lote #(
        .LARGURA (LARGURA)
    ) u_lote (
        .clk      (clk),
        .clr      (clr),
        .load     (carrega_lote),
        .enable   (passo_xfer),
        .valor    (lote_ini),
        .contagem (lote_cnt),
        .zero     (lote_zero)
    );

    always_comb begin
        soma       = {1'b0, buf_secundario} + {1'b0, qtd_reg};
        cabe       = (soma <= (LARGURA+1)'(CAP_MAX));
        folga      = LARGURA'(CAP_MAX) - buf_principal;
        passo_xfer = (est == EST_XFER) && enable && !lote_zero;
        passo_cons = consumo && enable && (buf_principal != '0);

        lote_ini = LARGURA'(LOTE);
        if (buf_secundario < lote_ini) lote_ini = buf_secundario;
        if (folga < lote_ini)          lote_ini = folga;
    end

    always_comb begin
        est_prox     = est;
        carrega_lote = 1'b0;
        case (est)
            EST_IDLE: begin
                if (pendente || req_carga) begin
                    est_prox = EST_LOAD;
                end else if (enable && (buf_principal < LARGURA'(MINIMO))
                             && (buf_secundario != '0)) begin
                    est_prox     = EST_XFER;
                    carrega_lote = 1'b1;
                end
            end
            EST_LOAD: est_prox = EST_IDLE;
            EST_XFER: begin
                if (lote_zero || (passo_xfer && (lote_cnt == LARGURA'(1))))
                    est_prox = EST_IDLE;
            end
            default:  est_prox = EST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            est          <= EST_IDLE;
            transferindo <= 1'b0;
            erro_carga   <= 1'b0;
        end else begin
            est          <= est_prox;
            transferindo <= (est_prox == EST_XFER);
            erro_carga   <= (est == EST_LOAD) && !cabe;
        end
    end

    // One holding register serves both immediate and deferred loads; a new
    // request always overwrites it, so the latest quantity wins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pendente <= 1'b0;
            qtd_reg  <= '0;
        end else if (est == EST_IDLE) begin
            pendente <= 1'b0;
            if (req_carga) qtd_reg <= qtd_carga;
        end else if (req_carga) begin
            pendente <= 1'b1;
            qtd_reg  <= qtd_carga;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            buf_secundario <= '0;
        end else if ((est == EST_LOAD) && cabe) begin
            buf_secundario <= soma[LARGURA-1:0];
        end else if (passo_xfer) begin
            buf_secundario <= buf_secundario - LARGURA'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            buf_principal <= '0;
        end else begin
            case ({passo_xfer, passo_cons})
                2'b10:   buf_principal <= buf_principal + LARGURA'(1);
                2'b01:   buf_principal <= buf_principal - LARGURA'(1);
                default: buf_principal <= buf_principal;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_controlador_transferencia_rolhas.sv
// Directed self-checking bench for the cork transfer controller.
module tb_modulo_controlador_transferencia_rolhas;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic       req_carga;
    logic [6:0] qtd_carga;
    logic       consumo;
    logic [6:0] buf_principal;
    logic [6:0] buf_secundario;
    logic       ro;
    logic       transferindo;
    logic       erro_carga;
    logic [1:0] estado;

    int vectors = 0;
    int fails   = 0;

    modulo_controlador_transferencia_rolhas #(
        .LARGURA (7),
        .CAP_MAX (99),
        .MINIMO  (5),
        .LOTE    (20)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .enable         (enable),
        .req_carga      (req_carga),
        .qtd_carga      (qtd_carga),
        .consumo        (consumo),
        .buf_principal  (buf_principal),
        .buf_secundario (buf_secundario),
        .ro             (ro),
        .transferindo   (transferindo),
        .erro_carga     (erro_carga),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b1; enable = 1'b1; req_carga = 1'b0; qtd_carga = '0; consumo = 1'b0;
        tick(); tick();
        clr = 1'b0;
        tick();
        chk("rst_main", int'(buf_principal), 0);
        chk("rst_sec", int'(buf_secundario), 0);
        chk("rst_estado", int'(estado), 0);
        chk("rst_xfer", int'(transferindo), 0);
        chk("rst_erro", int'(erro_carga), 0);
        chk("rst_ro", int'(ro), 1);

        // Load 40, then a 20-cork refill
        req_carga = 1'b1; qtd_carga = 7'd40;
        tick();
        req_carga = 1'b0;
        chk("load40_estado", int'(estado), 1);
        tick();
        chk("load40_sec", int'(buf_secundario), 40);
        chk("load40_idle", int'(estado), 0);
        tick();
        chk("xfer1_estado", int'(estado), 2);
        chk("xfer1_flag", int'(transferindo), 1);
        tick();
        chk("xfer1_main1", int'(buf_principal), 1);
        chk("xfer1_sec39", int'(buf_secundario), 39);
        repeat (19) tick();
        chk("xfer1_main", int'(buf_principal), 20);
        chk("xfer1_sec", int'(buf_secundario), 20);
        chk("xfer1_end", int'(estado), 0);
        chk("xfer1_flag0", int'(transferindo), 0);
        chk("xfer1_ro", int'(ro), 0);

        // Drain to 4, refill with consumption and a mid-batch load
        consumo = 1'b1;
        repeat (16) tick();
        consumo = 1'b0;
        chk("drain_main4", int'(buf_principal), 4);
        chk("drain_idle", int'(estado), 0);
        tick();
        chk("xfer2_estado", int'(estado), 2);
        consumo = 1'b1;
        tick();
        req_carga = 1'b1; qtd_carga = 7'd5;
        tick();
        req_carga = 1'b0;
        repeat (3) tick();
        consumo = 1'b0;
        chk("xfer2_cons_main", int'(buf_principal), 4);
        chk("xfer2_cons_sec", int'(buf_secundario), 15);
        repeat (15) tick();
        chk("xfer2_main", int'(buf_principal), 19);
        chk("xfer2_sec", int'(buf_secundario), 0);
        chk("xfer2_end", int'(estado), 0);
        tick();
        chk("pend_load", int'(estado), 1);
        tick();
        chk("pend_sec", int'(buf_secundario), 5);
        chk("pend_idle", int'(estado), 0);

        // Overflow rejection and exact fill to capacity
        req_carga = 1'b1; qtd_carga = 7'd85;
        tick();
        req_carga = 1'b0;
        tick();
        chk("sec90", int'(buf_secundario), 90);
        req_carga = 1'b1; qtd_carga = 7'd15;
        tick();
        req_carga = 1'b0;
        tick();
        chk("ovf_erro", int'(erro_carga), 1);
        chk("ovf_sec", int'(buf_secundario), 90);
        tick();
        chk("ovf_erro_pulse", int'(erro_carga), 0);
        req_carga = 1'b1; qtd_carga = 7'd9;
        tick();
        req_carga = 1'b0;
        tick();
        chk("sec99", int'(buf_secundario), 99);
        chk("sec99_erro", int'(erro_carga), 0);

        // Enable low mid-batch, then clear mid-batch
        consumo = 1'b1;
        repeat (15) tick();
        consumo = 1'b0;
        tick();
        chk("xfer3_estado", int'(estado), 2);
        repeat (3) tick();
        chk("xfer3_main", int'(buf_principal), 7);
        chk("xfer3_sec", int'(buf_secundario), 96);
        enable = 1'b0; consumo = 1'b1;
        repeat (4) tick();
        consumo = 1'b0;
        chk("hold_main", int'(buf_principal), 7);
        chk("hold_sec", int'(buf_secundario), 96);
        chk("hold_estado", int'(estado), 2);
        chk("hold_flag", int'(transferindo), 1);
        enable = 1'b1;
        repeat (2) tick();
        chk("resume_main", int'(buf_principal), 9);
        chk("resume_sec", int'(buf_secundario), 94);
        #2 clr = 1'b1;
        #1;
        chk("clr_main", int'(buf_principal), 0);
        chk("clr_sec", int'(buf_secundario), 0);
        chk("clr_estado", int'(estado), 0);
        chk("clr_flag", int'(transferindo), 0);
        @(negedge clk) clr = 1'b0;

        // Main 3 / secondary 7 gives a 7-cork batch
        enable = 1'b0;
        req_carga = 1'b1; qtd_carga = 7'd10;
        tick();
        req_carga = 1'b0;
        tick();
        chk("c_sec10", int'(buf_secundario), 10);
        enable = 1'b1;
        tick();
        chk("c_xfer_estado", int'(estado), 2);
        repeat (10) tick();
        chk("c_main10", int'(buf_principal), 10);
        chk("c_sec0", int'(buf_secundario), 0);
        consumo = 1'b1;
        repeat (7) tick();
        consumo = 1'b0;
        chk("c_main3", int'(buf_principal), 3);
        enable = 1'b0;
        req_carga = 1'b1; qtd_carga = 7'd7;
        tick();
        req_carga = 1'b0;
        tick();
        chk("c_sec7", int'(buf_secundario), 7);
        enable = 1'b1;
        tick();
        chk("c7_estado", int'(estado), 2);
        tick();
        chk("c7_main4", int'(buf_principal), 4);
        repeat (6) tick();
        chk("c7_main", int'(buf_principal), 10);
        chk("c7_sec", int'(buf_secundario), 0);
        chk("c7_end", int'(estado), 0);
        repeat (2) tick();
        chk("c7_no_rearm", int'(estado), 0);
        chk("c7_no_flag", int'(transferindo), 0);

        // Consumption at empty main never underflows
        consumo = 1'b1;
        repeat (10) tick();
        chk("empty_main", int'(buf_principal), 0);
        chk("empty_ro", int'(ro), 1);
        repeat (3) tick();
        consumo = 1'b0;
        chk("under_main", int'(buf_principal), 0);
        chk("under_ro", int'(ro), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/modulo_controlador_transferencia_rolhas.md
# modulo_controlador_transferencia_rolhas

Sequences cork (rolha) stock between the secondary warehouse buffer and the main buffer that feeds the sealing station. It shares both buffers between three requesters: operator loads into the secondary buffer, automatic refill transfers from secondary to main, and per-bottle consumption from main. It sits beside the filling/sealing MEF. It supplies `ro` and the buffer counts to the MEF and to the display encoders.

## Interface
Parameters:
- `LARGURA`, 7: buffer count width.
- `CAP_MAX`, 99: capacity of each buffer.
- `MINIMO`, 5: refill is triggered when main < MINIMO.
- `LOTE`, 20: maximum corks moved per refill.

Ports:
- `clk` in 1: system clock (divided clock domain). Everything is on its rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `enable` in 1: run enable (start_stop). Low freezes transfer and consumption.
- `req_carga` in 1: single-cycle pulse, operator load request.
- `qtd_carga` in LARGURA: corks to add to secondary. Sampled with `req_carga`.
- `consumo` in 1: single-cycle pulse, one cork used by the sealer.
- `buf_principal` out LARGURA: main buffer count.
- `buf_secundario` out LARGURA: secondary buffer count.
- `ro` out 1: main buffer empty (combinational from `buf_principal` == 0).
- `transferindo` out 1: high while in XFER.
- `erro_carga` out 1: one-cycle pulse, load rejected.
- `estado` out 2: 0 IDLE, 1 LOAD, 2 XFER.

## Operation
- Reset values:
  - `buf_principal` = 0, `buf_secundario` = 0.
  - State IDLE, `erro_carga` = 0, `transferindo` = 0.
  - Pending-load latch cleared.
  - Batch counter = 0.
- IDLE:
  - If pending or `req_carga` is set, go to LOAD. Load has priority over refill.
  - Else, if `enable` && `buf_principal` < MINIMO && `buf_secundario` > 0, go to XFER.
  - On XFER entry, the batch counter is loaded with min(LOTE, `buf_secundario`, CAP_MAX − `buf_principal`).
- LOAD (exactly 1 cycle), then back to IDLE:
  - If `buf_secundario` + `qtd_carga` ≤ CAP_MAX, `buf_secundario` += `qtd_carga`.
  - Otherwise `buf_secundario` is unchanged and `erro_carga` = 1 for that cycle.
  - `qtd_carga` = 0 is accepted with no change.
  - The sum is computed 8 bits wide; no wrap.
- XFER:
  - Each cycle with `enable` = 1: `buf_secundario` −1, `buf_principal` +1, batch counter −1.
  - Return to IDLE on the cycle the counter reaches 0.
  - `enable` = 0 holds all registers; state stays XFER.
- `req_carga` outside IDLE: latched into the pending latch, together with `qtd_carga` in a holding register.
  - The latch is served on the next IDLE cycle.
  - A second request while one is pending overwrites the held quantity (last wins).
- `consumo` with `enable` = 1 and `buf_principal` > 0: `buf_principal` −1, in any state.
  - When it coincides with an XFER step, the net main change is 0. Secondary still decrements and the batch counter still counts.
  - `consumo` at `buf_principal` = 0 is ignored. Never underflows.
  - `consumo` with `enable` = 0 is ignored.
- Invariants: neither buffer ever exceeds CAP_MAX or goes below 0.

## Timing
- All outputs except `ro` are registered. `ro` follows `buf_principal` combinationally.
- Load latency:
  - `req_carga` at edge N → LOAD during cycle N+1 → count updated at edge N+2.
  - If pending (request arrived outside IDLE), the update is one IDLE cycle later.
- Refill latency: condition true in IDLE at edge N → first transfer at edge N+2. A k-cork batch occupies k XFER cycles.
- Refill re-arms: after XFER ends, IDLE re-evaluates. Consumption during the batch can re-trigger a further refill.
- `clr` mid-XFER or mid-LOAD: immediate return to reset values. The partial batch is not rolled back; buffers are zeroed.

## Structure
- Shared package/include holds:
  - State encodings: `EST_IDLE`, `EST_LOAD`, `EST_XFER`.
  - Constants `CAP_MAX`, `MINIMO`, `LOTE`, `LARGURA`.
  - These are reused by the display encoders and the MEF.
- One sub-module, `modulo_contador_lote`:
  - Loadable down-counter (LARGURA bits) with async `clr`, `load`, `enable`, `zero` flag.
- The FSM, buffer registers and arbitration are in the top of this block.

## Test plan
- Reset, then `req_carga` with `qtd_carga` = 40 → `buf_secundario` = 40 at N+2. `enable` = 1, main 0 < 5 → XFER.
  - 20 cycles later: main = 20, secondary = 20, state IDLE.
- Secondary 90, `req_carga` with `qtd_carga` = 15 → `erro_carga` pulses 1 cycle, secondary stays 90.
  - Then `qtd_carga` = 9 → secondary = 99.
- Main 3, secondary 7 → batch = 7. Main ends at 10, secondary at 0, no further XFER.
- During XFER, `consumo` every cycle for 5 cycles → main unchanged over those cycles, secondary −5.
  - `req_carga` issued mid-XFER is applied in the first IDLE cycle after XFER.
- Main 0, `consumo` pulses → main stays 0, `ro` = 1.
- `enable` low mid-XFER holds all values.
- `clr` asserted mid-batch zeroes both buffers asynchronously. State returns to IDLE.
